// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared state encoding, digit count, blanking constants and
//               hex to seven-segment (active-low gfedcba) decode.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] c_BLANK_EN  = 8'hFF;
    localparam logic [6:0] c_BLANK_SEG = 7'h7F;

    function automatic logic [6:0] hex7(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        case (i_nib)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Combinational 4-way round-robin pick: first set request bit
//               at or after rr_ptr, wrapping modulo 4.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] index
);

    always_comb begin
        valid = |req;
        index = rr_ptr;
        // Scan from the farthest offset down so the nearest set bit wins.
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_ptr + 2'(k)]) begin
                index = rr_ptr + 2'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scheduler
// Description : Round-robin sharing of an 8-digit multiplexed seven-segment
//               display; snapshots the winner's value and holds it for a
//               fixed number of scan frames.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scheduler
    import disp_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                    Clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      req,
    input  logic [32*NUM_SRC-1:0]   val,
    output logic [NUM_SRC-1:0]      ack,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic [6:0]              out7,
    output logic [NUM_DIGITS-1:0]   en_out
);

    localparam int c_TICK_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_FRAME_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(SCAN_DIV - 1);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(HOLD_FRAMES - 1);

    state_t                 r_state;
    logic [NUM_SRC-1:0]     r_ack;
    logic [1:0]             r_owner;
    logic                   r_busy;
    logic [NUM_DIGITS-1:0]  r_en_out;
    logic [6:0]             r_out7;
    logic [1:0]             r_rr_ptr;
    logic [2:0]             r_digit;
    logic [c_TICK_W-1:0]    r_tick;
    logic [c_FRAME_W-1:0]   r_frame;
    logic [31:0]            r_shadow;

    logic [1:0]             w_arb_ptr;
    logic                   w_arb_valid;
    logic [1:0]             w_arb_idx;
    logic                   w_tick_wrap;
    logic                   w_end_hold;

    // At end of hold the arbiter must already see the advanced pointer.
    assign w_arb_ptr   = (r_state == SHOW) ? (r_owner + 2'd1) : r_rr_ptr;
    assign w_tick_wrap = (r_tick == c_TICK_LAST);
    assign w_end_hold  = (r_state == SHOW) && w_tick_wrap &&
                         (r_digit == 3'd7) && (r_frame == c_FRAME_LAST);

    rr_arbiter4 u_arb (
        .req    (req),
        .rr_ptr (w_arb_ptr),
        .valid  (w_arb_valid),
        .index  (w_arb_idx)
    );

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ack    <= '0;
            r_owner  <= 2'd0;
            r_busy   <= 1'b0;
            r_en_out <= c_BLANK_EN;
            r_out7   <= c_BLANK_SEG;
            r_rr_ptr <= 2'd0;
            r_digit  <= 3'd0;
            r_tick   <= '0;
            r_frame  <= '0;
            r_shadow <= 32'd0;
        end else begin
            r_ack <= '0;

            if (r_state == SHOW) begin
                r_en_out <= ~(8'b1 << r_digit);
                r_out7   <= hex7(r_shadow[{r_digit, 2'b00} +: 4]);
            end else begin
                r_en_out <= c_BLANK_EN;
                r_out7   <= c_BLANK_SEG;
            end

            if ((r_state == IDLE || w_end_hold) && w_arb_valid) begin
                if (w_end_hold) begin
                    r_rr_ptr <= r_owner + 2'd1;
                end
                r_shadow <= val[{w_arb_idx, 5'b0} +: 32];
                r_ack    <= NUM_SRC'(1) << w_arb_idx;
                r_owner  <= w_arb_idx;
                r_busy   <= 1'b1;
                r_digit  <= 3'd0;
                r_tick   <= '0;
                r_frame  <= '0;
                r_state  <= SHOW;
            end else if (w_end_hold) begin
                r_rr_ptr <= r_owner + 2'd1;
                r_busy   <= 1'b0;
                r_digit  <= 3'd0;
                r_tick   <= '0;
                r_frame  <= '0;
                r_state  <= IDLE;
            end else if (r_state == SHOW) begin
                if (w_tick_wrap) begin
                    r_tick  <= '0;
                    r_digit <= r_digit + 3'd1;
                    if (r_digit == 3'd7) begin
                        r_frame <= r_frame + 1'b1;
                    end
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

    assign ack    = r_ack;
    assign owner  = r_owner;
    assign busy   = r_busy;
    assign out7   = r_out7;
    assign en_out = r_en_out;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scheduler
// Description : Self-checking bench: constant vector table, hand sequences
//               and random traffic against a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

    localparam int SCAN_DIV    = 2;
    localparam int HOLD_FRAMES = 2;
    localparam int HOLD_CLKS   = HOLD_FRAMES * 8 * SCAN_DIV;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic         Clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'h0;
    logic [127:0] val = '0;
    logic [3:0]   ack;
    logic [1:0]   owner;
    logic         busy;
    logic [6:0]   out7;
    logic [7:0]   en_out;

    always #5 Clk = ~Clk;

    seg_display_scheduler #(
        .NUM_SRC     (4),
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .Clk    (Clk),
        .rst    (rst),
        .req    (req),
        .val    (val),
        .ack    (ack),
        .owner  (owner),
        .busy   (busy),
        .out7   (out7),
        .en_out (en_out)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: elapsed clocks since grant, display derived arithmetically.
    bit          m_busy   = 1'b0;
    int          m_cnt    = 0;
    logic [1:0]  m_owner  = 2'd0;
    logic [1:0]  m_ptr    = 2'd0;
    logic [31:0] m_shadow = 32'd0;
    logic [3:0]  m_ack    = 4'h0;
    logic [7:0]  m_en     = 8'hFF;
    logic [6:0]  m_seg    = 7'h7F;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic m_grant(input logic [1:0] p);
        bit done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] s;
            s = p + 2'(k);
            if (!done && req[s]) begin
                done     = 1'b1;
                m_shadow = val[32*s +: 32];
                m_ack    = 4'h1 << s;
                m_owner  = s;
                m_busy   = 1'b1;
                m_cnt    = 0;
            end
        end
    endtask

    task automatic model_step();
        int d;
        logic [3:0] nib;
        logic [7:0] ne;
        logic [6:0] ns;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_owner = 0; m_ptr = 0; m_shadow = 0;
            m_ack = 0; m_en = 8'hFF; m_seg = 7'h7F;
        end else begin
            d   = (m_cnt / SCAN_DIV) % 8;
            nib = m_shadow[4*d +: 4];
            ne  = m_busy ? ~(8'h01 << d) : 8'hFF;
            ns  = m_busy ? HEX_TAB[nib] : 7'h7F;
            m_ack = 4'h0;
            if (!m_busy) begin
                if (req != 4'h0) m_grant(m_ptr);
            end else if (m_cnt == HOLD_CLKS - 1) begin
                m_ptr = m_owner + 2'd1;
                if (req != 4'h0) m_grant(m_ptr);
                else m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
            m_en  = ne;
            m_seg = ns;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
        model_step();
        chk("m_ack", ack, m_ack);
        chk("m_owner", owner, m_owner);
        chk("m_busy", busy, m_busy);
        chk("m_en", en_out, m_en);
        chk("m_seg", out7, m_seg);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] ack;
        logic [1:0] own;
        logic       busy;
        logic [7:0] en;
        logic [6:0] seg;
    } vec_t;

    vec_t tab [19];

    initial begin
        int q_cyc[$];
        int q_own[$];
        int ff_cnt, a3_cnt, first_g;
        int exp_ord [5] = '{0, 1, 2, 3, 0};

        tab[0]  = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 8'hFF, 7'h7F};
        tab[1]  = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 8'hFF, 7'h7F};
        tab[2]  = '{1'b0, 4'h2, 4'h2, 2'd1, 1'b1, 8'hFF, 7'h7F};
        tab[3]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFE, 7'h00};
        tab[4]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFE, 7'h00};
        tab[5]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFD, 7'h78};
        tab[6]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFD, 7'h78};
        tab[7]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFB, 7'h02};
        tab[8]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hFB, 7'h02};
        tab[9]  = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hF7, 7'h12};
        tab[10] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hF7, 7'h12};
        tab[11] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hEF, 7'h19};
        tab[12] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hEF, 7'h19};
        tab[13] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hDF, 7'h30};
        tab[14] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hDF, 7'h30};
        tab[15] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hBF, 7'h24};
        tab[16] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'hBF, 7'h24};
        tab[17] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'h7F, 7'h79};
        tab[18] = '{1'b0, 4'h0, 4'h0, 2'd1, 1'b1, 8'h7F, 7'h79};

        // Single request from source 1 with a known value.
        val = {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h0BADF00D};
        for (int i = 0; i < 19; i++) begin
            rst = tab[i].rst;
            req = tab[i].req;
            tick();
            chk("tab_ack", ack, tab[i].ack);
            chk("tab_owner", owner, tab[i].own);
            chk("tab_busy", busy, tab[i].busy);
            chk("tab_en", en_out, tab[i].en);
            chk("tab_seg", out7, tab[i].seg);
        end
        repeat (16) tick();
        chk("hold_end_busy", busy, 1'b0);
        chk("hold_end_en", en_out, 8'h7F);
        chk("hold_end_seg", out7, 7'h79);
        tick();
        chk("idle_en", en_out, 8'hFF);
        chk("idle_seg", out7, 7'h7F);

        // Round-robin with all requests held from reset.
        rst = 1'b1; req = 4'hF;
        tick(); tick();
        chk("rst_ack", ack, 4'h0);
        chk("rst_en", en_out, 8'hFF);
        rst = 1'b0;
        ff_cnt = 0; first_g = -1;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (ack != 4'h0) begin
                q_cyc.push_back(cyc);
                q_own.push_back(int'(owner));
                if (first_g < 0) first_g = cyc;
            end else if (first_g >= 0 && q_cyc.size() < 5 && en_out == 8'hFF) begin
                ff_cnt++;
            end
        end
        chk("rr_grants", q_cyc.size(), 5);
        for (int i = 0; i < 5 && i < q_own.size(); i++) begin
            chk("rr_order", q_own[i], exp_ord[i]);
            if (i > 0) chk("rr_spacing", q_cyc[i] - q_cyc[i-1], HOLD_CLKS);
        end
        chk("rr_no_blank", ff_cnt, 0);
        req = 4'h0;

        // Snapshot isolation: source 0 value changes mid-hold.
        do_reset();
        val = '0; req = 4'h1;
        tick();
        chk("snap_ack", ack, 4'h1);
        req = 4'h0;
        repeat (10) tick();
        val[31:0] = 32'hFFFFFFFF;
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("snap_seg", out7, 7'h40);
        end
        tick();

        // Reset mid-SHOW discards the display and the advanced pointer.
        do_reset();
        req = 4'h2;
        tick();
        req = 4'h0;
        repeat (HOLD_CLKS) tick();
        req = 4'h1;
        tick();
        chk("mid_pre_owner", owner, 2'd0);
        req = 4'h0;
        repeat (22) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_en", en_out, 8'hFF);
        chk("mid_rst_seg", out7, 7'h7F);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ack", ack, 4'h0);
        chk("mid_rst_owner", owner, 2'd0);
        rst = 1'b0; req = 4'h5;
        tick();
        chk("mid_post_ack", ack, 4'h1);
        repeat (HOLD_CLKS) tick();
        chk("mid_next_owner", owner, 2'd2);
        chk("mid_next_ack", ack, 4'h4);
        req = 4'h0;
        repeat (HOLD_CLKS + 2) tick();

        // Lone repeat with a short-lived competing request.
        do_reset();
        req = 4'h4;
        tick();
        chk("lone_ack1", ack, 4'h4);
        q_cyc.delete();
        a3_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) req = 4'hC;
            if (k == 8) req = 4'h4;
            tick();
            if (ack[2]) q_cyc.push_back(k);
            if (ack[3]) a3_cnt++;
        end
        chk("lone_reacks", q_cyc.size(), 1);
        if (q_cyc.size() > 0) chk("lone_reack_at", q_cyc[0], HOLD_CLKS);
        chk("dropped_src3", a3_cnt, 0);
        req = 4'h0;

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) val[32*$urandom_range(0, 3) +: 32] = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Shares the 8-digit multiplexed seven-segment display between up to four requesters that each want to show a 32-bit value (processor registers, debug counters, and so on). Requesters are served round-robin. The winner's value is snapshotted and held on the display for a fixed number of scan frames. The block also generates the digit scan and hex-to-segment decode. It sits between the processor/datapath outputs and the board pins, all on the undivided board clock.

## Interface
Parameters:
- NUM_SRC, 4: number of requesters; fixed at 4 in this revision.
- SCAN_DIV, 100000: clocks each digit stays enabled; must be ≥1.
- HOLD_FRAMES, 250: full 8-digit frames a granted value is displayed; must be ≥1.

Ports:
- Clk, input, 1: board clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 4: per-source display request; level, held until ack.
- val, input, 128: source i value at val[32*i+31:32*i].
- ack, output, 4: one-cycle pulse to the source whose value was captured.
- owner, output, 2: index of the source currently displayed.
- busy, output, 1: high while a value is being displayed.
- out7, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- en_out, output, 8: digit enables, active-low; bit 0 is the rightmost digit.

## Operation
- States are IDLE and SHOW.
- Reset values:
  - state=IDLE; ack=0; owner=0; busy=0; en_out=8'hFF; out7=7'h7F.
  - rr_ptr=0, digit=0, tick=0, frame=0, shadow=0.
- Grant from IDLE: when any req bit is sampled high, the highest-priority requester is the first set bit at or after rr_ptr, wrapping modulo 4. On that edge the block:
  - loads shadow ← that source's val slice;
  - sets ack[i]=1 for exactly one cycle, owner=i and busy=1;
  - clears digit, tick and frame, and enters SHOW.
- SHOW scan:
  - tick counts 0..SCAN_DIV-1. On wrap, digit increments 0..7.
  - On digit wrap 7→0, frame increments.
- End of hold: the edge where tick=SCAN_DIV-1, digit=7 and frame=HOLD_FRAMES-1.
  - rr_ptr ← owner+1 mod 4.
  - The arbiter is evaluated against the new rr_ptr in the same edge.
  - If any req is high, grant immediately (back-to-back, no blank cycle, digit restarts at 0). Otherwise go to IDLE with busy=0.
- A lone requester that keeps req high is re-granted after its own hold and receives a fresh ack pulse.
- Requests are not captured outside grant edges. Changes to val after capture have no effect on the display.
- If req drops before being granted, that source is not served and gets no ack.
- Outputs:
  - en_out and out7 are registered from state, digit and shadow.
  - In SHOW: en_out = ~(8'b1 << digit) and out7 = hex7(shadow[4*digit+3:4*digit]).
  - In IDLE: en_out=8'hFF and out7=7'h7F.
- hex7, active-low gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- rst asserted in any state returns all registers to reset values on the next edge. The in-flight display is discarded, no ack is issued, and rr_ptr resets to 0.

## Timing
- If req is first sampled high at edge t while IDLE, the grant happens at t: ack, owner and busy are visible after edge t.
- ack is high for exactly one cycle, then cleared at t+1.
- en_out/out7 show digit 0 of the new value after edge t+1, giving 1-cycle output latency.
- Each digit is enabled for exactly SCAN_DIV clocks, and one frame is 8·SCAN_DIV clocks.
- With back-to-back grants, successive ack pulses are exactly HOLD_FRAMES·8·SCAN_DIV clocks apart.
- The final digit of the old value is displayed until the edge after the end-of-hold edge.

## Structure
- The shared package disp_pkg holds:
  - the state encoding (IDLE, SHOW);
  - NUM_DIGITS=8;
  - the hex7 segment constants/function;
  - the blank constants 8'hFF and 7'h7F.
- Sub-module rr_arbiter4 is a combinational 4-way round-robin pick with inputs req and rr_ptr and outputs valid and a 2-bit index. It is reused by other shared-resource controllers.

## Test plan
All scenarios use SCAN_DIV=2 and HOLD_FRAMES=2, so one hold is 32 clocks.
- **Reset:** hold rst 2 cycles with req=4'hF → en_out=FF, out7=7F, ack=0, busy=0; first grant after release goes to source 0.
- **Single request:** source 1 requests with val=0x12345678.
  - ack=4'b0010 for one cycle, owner=1.
  - en_out steps FE, FD, …, 7F, two clocks each; out7=00 while FE is active and 79 while 7F is active.
  - After 32 clocks with no other request → IDLE, en_out=FF, busy=0.
- **Round-robin:** req=4'hF held → grant order 0, 1, 2, 3, 0, with ack pulses 32 clocks apart and en_out never FF between grants.
- **Snapshot isolation:** src0 val changes 0x0 → 0xFFFFFFFF mid-hold → out7 stays 40 for the rest of the hold.
- **Reset mid-SHOW:** assert rst at frame 1, digit 3 → next edge gives all reset values; a following request from source 2 is granted with rr_ptr=0 semantics.
- **Lone repeat / dropped request:**
  - src2 holds req alone → regranted after 32 clocks with a second ack[2] pulse.
  - src3 pulses req during src2's hold → never acked.
